// File: rtl/apb_mc_pkg.sv
// Shared types for the multi-slave APB requester.
// The request register width follows the package widths below; the top's
// ADDR_W/DATA_W parameters default to these values.
package apb_mc_pkg;

  localparam int unsigned REQ_ADDR_W = 12;
  localparam int unsigned REQ_DATA_W = 32;
  localparam int unsigned REQ_STRB_W = REQ_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  // Captured request: direction, byte address, write data and strobes.
  typedef struct packed {
    logic                  write;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
    logic [REQ_STRB_W-1:0] strb;
  } apb_req_t;

  // Ceiling log2, used for select and wait-counter widths.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_rsp_mux.sv
// One-hot response mux: picks the selected slave's pready/pslverr/prdata.
// Ports:
//   sel_onehot  one-hot slave select (registered psel)
//   pready/pslverr/prdata  per-slave response inputs
//   pready_c/pslverr_c/prdata_c  selected slave's response (combinational)
module apb_rsp_mux #(
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned DATA_W  = 32
) (
  input  logic [NUM_SLV-1:0]        sel_onehot,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  output logic                      pready_c,
  output logic                      pslverr_c,
  output logic [DATA_W-1:0]         prdata_c
);

  // AND-OR select; unselected slaves contribute nothing.
  always_comb begin
    pready_c  = |(sel_onehot & pready);
    pslverr_c = |(sel_onehot & pslverr);
    prdata_c  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_onehot[i]) begin
        prdata_c = prdata_c | prdata[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/apb_master_mc.sv
// Multi-slave APB4 requester: accepts single-beat requests on a valid/ready
// port, runs SETUP/ACCESS on the decoded slave, and returns a one-cycle
// response pulse with read data, error and timeout status.
// Ports:
//   pclk, presetn                 clock, synchronous active-low reset
//   req_valid/req_ready/req_*     request port (req_ready is combinational)
//   rsp_valid/rsp_rdata/rsp_err/rsp_timeout  registered response
//   psel/penable/pwrite/paddr/pwdata/pstrb   registered APB outputs
//   pready/prdata/pslverr         per-slave APB responses
module apb_master_mc
  import apb_mc_pkg::*;
#(
  parameter int unsigned ADDR_W  = REQ_ADDR_W,
  parameter int unsigned DATA_W  = REQ_DATA_W,
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [DATA_W/8-1:0]       req_strb,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  output logic [DATA_W/8-1:0]       pstrb,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pslverr
);

  localparam int unsigned SEL_W  = clog2(NUM_SLV);
  localparam int unsigned CNT_W  = clog2(TIMEOUT);
  localparam int unsigned STRB_W = DATA_W / 8;

  state_e              state_q, state_d;
  apb_req_t            req_q, req_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  logic                sel_pready_c;
  logic                sel_pslverr_c;
  logic [DATA_W-1:0]   sel_prdata_c;
  logic                timeout_hit_c;
  logic                done_c;

  // psel_q is only non-zero in SETUP/ACCESS, so it doubles as the mux select.
  apb_rsp_mux #(
    .NUM_SLV (NUM_SLV),
    .DATA_W  (DATA_W)
  ) u_rsp_mux (
    .sel_onehot (psel_q),
    .pready     (pready),
    .pslverr    (pslverr),
    .prdata     (prdata),
    .pready_c   (sel_pready_c),
    .pslverr_c  (sel_pslverr_c),
    .prdata_c   (sel_prdata_c)
  );

  // Next state, request capture, wait counter, response and APB outputs.
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    req_ready     = 1'b0;
    psel_d        = '0;
    penable_d     = 1'b0;
    pwrite_d      = 1'b0;
    paddr_d       = '0;
    pwdata_d      = '0;
    pstrb_d       = '0;

    timeout_hit_c = (cnt_q == CNT_W'(TIMEOUT - 1));
    done_c        = (state_q == ACCESS) && (sel_pready_c || timeout_hit_c);

    case (state_q)
      IDLE: begin
        req_ready = presetn;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (done_c) begin
          req_ready   = presetn;
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          // pready wins over a simultaneous timeout.
          if (sel_pready_c) begin
            rsp_rdata_d   = req_q.write ? '0 : sel_prdata_c;
            rsp_err_d     = sel_pslverr_c;
            rsp_timeout_d = 1'b0;
          end else begin
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (req_valid && req_ready) begin
      state_d     = SETUP;
      req_d.write = req_write;
      req_d.addr  = req_addr;
      req_d.wdata = req_wdata;
      req_d.strb  = req_strb;
    end

    // APB outputs are derived from where the FSM is heading next.
    if (state_d != IDLE) begin
      psel_d[req_d.addr[ADDR_W-1 -: SEL_W]] = 1'b1;
      penable_d = (state_d == ACCESS);
      pwrite_d  = req_d.write;
      paddr_d   = req_d.addr;
      if (req_d.write) begin
        pwdata_d = req_d.wdata;
        pstrb_d  = req_d.strb;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q       <= IDLE;
      req_q         <= '0;
      cnt_q         <= '0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_mc.sv
// Bench for apb_master_mc: directed scenarios plus randomized transfers,
// each checked against a transfer-level expectation computed from the
// slave's wait count, error flag and read data.
module tb_apb_master_mc;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_SLV = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned SEL_W   = 2;

  logic                      pclk = 1'b0;
  logic                      presetn;
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [ADDR_W-1:0]         req_addr;
  logic [DATA_W-1:0]         req_wdata;
  logic [STRB_W-1:0]         req_strb;
  logic                      rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      rsp_timeout;
  logic [NUM_SLV-1:0]        psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata;
  logic [STRB_W-1:0]         pstrb;
  logic [NUM_SLV-1:0]        pready;
  logic [NUM_SLV*DATA_W-1:0] prdata;
  logic [NUM_SLV-1:0]        pslverr;

  int checks   = 0;
  int failures = 0;

  always #5 pclk = ~pclk;

  apb_master_mc #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NUM_SLV (NUM_SLV),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_strb    (req_strb),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pstrb       (pstrb),
    .pready      (pready),
    .prdata      (prdata),
    .pslverr     (pslverr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Selected slave gets the given response; others show noise that must be ignored.
  task automatic drive_slaves(input int sel, input bit rdy, input bit err,
                              input logic [DATA_W-1:0] rd);
    for (int i = 0; i < int'(NUM_SLV); i++) begin
      if (i == sel) begin
        pready[i]  = rdy;
        pslverr[i] = err;
        prdata[i*DATA_W +: DATA_W] = rd;
      end else begin
        pready[i]  = 1'($urandom);
        pslverr[i] = 1'b1;
        prdata[i*DATA_W +: DATA_W] = $urandom;
      end
    end
  endtask

  function automatic logic [NUM_SLV-1:0] onehot_of(input logic [ADDR_W-1:0] a);
    logic [NUM_SLV-1:0] one;
    one = 1;
    return one << (a >> (ADDR_W - SEL_W));
  endfunction

  // One complete transfer from IDLE. wait_n = number of pready-low ACCESS cycles.
  task automatic xfer(input string tag, input bit wr, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wd, input logic [STRB_W-1:0] st,
                      input int wait_n, input bit serr, input logic [DATA_W-1:0] rd);
    int                 sel;
    int                 acc;
    int                 exp_acc;
    bit                 tmo;
    logic [DATA_W-1:0]  exp_rd;
    logic [NUM_SLV-1:0] exp_psel;
    sel      = int'(addr >> (ADDR_W - SEL_W));
    exp_psel = onehot_of(addr);
    tmo      = (wait_n >= int'(TIMEOUT));
    exp_acc  = tmo ? int'(TIMEOUT) : wait_n + 1;
    exp_rd   = (tmo || wr) ? '0 : rd;

    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_strb = st;
    drive_slaves(sel, 1'b0, 1'b0, rd);
    #1;
    check({tag, ".ready_idle"}, 64'(req_ready), 64'(1));
    @(posedge pclk); @(negedge pclk);
    // Scramble the port: the request register must hold the accepted values.
    req_valid = 1'b0; req_addr = ADDR_W'($urandom); req_wdata = $urandom;
    req_strb = STRB_W'($urandom); req_write = 1'($urandom);
    #1;
    check({tag, ".setup_psel"},    64'(psel),      64'(exp_psel));
    check({tag, ".setup_penable"}, 64'(penable),   64'(0));
    check({tag, ".setup_pwrite"},  64'(pwrite),    64'(wr));
    check({tag, ".setup_paddr"},   64'(paddr),     64'(addr));
    check({tag, ".setup_pwdata"},  64'(pwdata),    64'(wr ? wd : '0));
    check({tag, ".setup_pstrb"},   64'(pstrb),     64'(wr ? st : '0));
    check({tag, ".setup_ready"},   64'(req_ready), 64'(0));
    acc = 0;
    @(posedge pclk); @(negedge pclk);
    while (penable === 1'b1 && acc < int'(TIMEOUT) + 4) begin
      acc++;
      drive_slaves(sel, acc > wait_n, serr, rd);
      #1;
      check({tag, ".access_psel"},  64'(psel),      64'(exp_psel));
      check({tag, ".access_rsp"},   64'(rsp_valid), 64'(0));
      check({tag, ".access_ready"}, 64'(req_ready),
            64'((acc > wait_n) || (acc == int'(TIMEOUT))));
      @(posedge pclk); @(negedge pclk);
    end
    check({tag, ".access_cycles"}, 64'(acc),         64'(exp_acc));
    check({tag, ".rsp_valid"},     64'(rsp_valid),   64'(1));
    check({tag, ".rsp_rdata"},     64'(rsp_rdata),   64'(exp_rd));
    check({tag, ".rsp_err"},       64'(rsp_err),     64'(tmo || serr));
    check({tag, ".rsp_timeout"},   64'(rsp_timeout), 64'(tmo));
    check({tag, ".idle_psel"},     64'(psel),        64'(0));
    drive_slaves(sel, 1'b0, 1'b0, rd);
    @(posedge pclk); @(negedge pclk);
    check({tag, ".rsp_pulse"},     64'(rsp_valid),   64'(0));
    check({tag, ".rsp_hold"},      64'(rsp_rdata),   64'(exp_rd));
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    presetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; pready = '0; prdata = '0; pslverr = '0;

    // Reset state.
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("reset.psel",      64'(psel),      64'(0));
    check("reset.penable",   64'(penable),   64'(0));
    check("reset.rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset.req_ready", 64'(req_ready), 64'(0));
    check("reset.paddr",     64'(paddr),     64'(0));
    presetn = 1'b1;
    @(posedge pclk); @(negedge pclk);

    xfer("wr_s1",  1'b1, 12'h404, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0);
    xfer("rd_s3",  1'b0, 12'hC10, 32'hCAFEF00D, 4'h5, 3, 1'b0, 32'h12345678);
    xfer("tmo_s2", 1'b0, 12'h800, 32'h0, 4'h0, 100, 1'b0, 32'hAAAA5555);
    xfer("err_s0", 1'b0, 12'h010, 32'h0, 4'h0, 1, 1'b1, 32'h0BADF00D);
    xfer("ok_s0",  1'b0, 12'h020, 32'h0, 4'h0, 0, 1'b0, 32'h600DD00D);
    xfer("edge_s1", 1'b0, 12'h4F0, 32'h0, 4'h0, int'(TIMEOUT) - 1, 1'b0, 32'h13579BDF);

    // Back-to-back: read slave0 then write slave2 with req_valid held.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h008; req_wdata = '0; req_strb = 4'h3;
    drive_slaves(0, 1'b0, 1'b0, 32'h0);
    @(posedge pclk); @(negedge pclk);
    req_write = 1'b1; req_addr = 12'h80C; req_wdata = 32'h11223344; req_strb = 4'hC;
    #1;
    check("b2b.setup1_psel",  64'(psel),      64'(4'b0001));
    check("b2b.setup1_ready", 64'(req_ready), 64'(0));
    @(posedge pclk); @(negedge pclk);
    drive_slaves(0, 1'b1, 1'b0, 32'h89ABCDEF);
    #1;
    check("b2b.access1_pen",   64'(penable),   64'(1));
    check("b2b.access1_ready", 64'(req_ready), 64'(1));
    @(posedge pclk); @(negedge pclk);
    req_valid = 1'b0;
    drive_slaves(2, 1'b0, 1'b0, 32'h0);
    #1;
    check("b2b.rsp1_valid",  64'(rsp_valid), 64'(1));
    check("b2b.rsp1_rdata",  64'(rsp_rdata), 64'(32'h89ABCDEF));
    check("b2b.setup2_psel", 64'(psel),      64'(4'b0100));
    check("b2b.setup2_pen",  64'(penable),   64'(0));
    check("b2b.setup2_pwd",  64'(pwdata),    64'(32'h11223344));
    check("b2b.setup2_strb", 64'(pstrb),     64'(4'hC));
    @(posedge pclk); @(negedge pclk);
    drive_slaves(2, 1'b1, 1'b0, 32'hFFFFFFFF);
    #1;
    check("b2b.access2_pen", 64'(penable),   64'(1));
    check("b2b.access2_rsp", 64'(rsp_valid), 64'(0));
    @(posedge pclk); @(negedge pclk);
    drive_slaves(2, 1'b0, 1'b0, 32'h0);
    check("b2b.rsp2_valid", 64'(rsp_valid), 64'(1));
    check("b2b.rsp2_rdata", 64'(rsp_rdata), 64'(0));
    check("b2b.rsp2_err",   64'(rsp_err),   64'(0));
    check("b2b.idle_psel",  64'(psel),      64'(0));
    @(posedge pclk); @(negedge pclk);

    // Reset during ACCESS drops the transfer.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h400;
    drive_slaves(1, 1'b0, 1'b0, 32'h0);
    @(posedge pclk); @(negedge pclk);
    req_valid = 1'b0;
    @(posedge pclk); @(negedge pclk);
    drive_slaves(1, 1'b0, 1'b0, 32'h0);
    check("rst_mid.access_pen", 64'(penable), 64'(1));
    presetn = 1'b0;
    @(posedge pclk); @(negedge pclk);
    check("rst_mid.psel",      64'(psel),      64'(0));
    check("rst_mid.penable",   64'(penable),   64'(0));
    check("rst_mid.rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_mid.rsp_rdata", 64'(rsp_rdata), 64'(0));
    presetn = 1'b1;
    @(posedge pclk); @(negedge pclk);
    #1;
    check("rst_mid.no_rsp",    64'(rsp_valid), 64'(0));
    check("rst_mid.req_ready", 64'(req_ready), 64'(1));

    // Randomized transfers.
    for (int n = 0; n < 30; n++) begin
      int w;
      w  = ($urandom_range(0, 6) == 0) ? int'(TIMEOUT) + int'($urandom_range(0, 4))
                                        : int'($urandom_range(0, 5));
      rd = $urandom;
      xfer($sformatf("rand%0d", n), 1'($urandom), ADDR_W'($urandom), $urandom,
           STRB_W'($urandom), w, ($urandom_range(0, 3) == 0), rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
